ipsmacge_rgmiirx: RTL and testbench

//  RGMII receive byte assembler for the GE MAC. Sits directly downstream of the DDR input register.
//  - Merges each low/high nibble pair into one byte.
//  - Decodes RX_DV and RX_ER from the control bit.
//  - Strips the preamble and SFD.
//  - Delivers a registered byte stream with SOP/EOP/ERR framing to the MAC receive core.

---
 rtl/ipsmacge_rgmiirx.sv | 203 ++++++++++++++++++++
 tb/tb_ipsmacge_rgmiirx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsmacge_rgmiirx.sv
// rtl/ipsmacge_rgmiirx.sv - RGMII receive byte assembler with preamble/SFD strip and SOP/EOP/ERR framing
// Optional in-band link/speed/duplex capture is enabled by defining IPSMACGE_INBAND_STS_EN.
module ipsmacge_rgmiirx #(
  parameter int MINPRE = 1,
  parameter int MAXLEN = 1536,
  parameter int LW     = 11
) (
  input  logic        rxclk,
  input  logic        rxrst,
  input  logic [4:0]  idat_h,
  input  logic [4:0]  idat_l,
  output logic [7:0]  odat,
  output logic        ovld,
  output logic        osop,
  output logic        oeop,
  output logic        oerr,
  output logic [15:0] oerrcnt,
  output logic        olink,
  output logic [1:0]  ospeed,
  output logic        odplx
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [LW-1:0] MAXLEN_C = LW'(MAXLEN);
  localparam logic [4:0]    MINPRE_C = 5'(MINPRE);

  logic [7:0]    s1_byte;
  logic          s1_dv;
  logic          s1_er;

  state_t        state, nstate;
  logic [3:0]    precnt, nprecnt;
  logic [LW-1:0] bcnt, nbcnt;
  logic [7:0]    hold, nhold;
  logic          hold_vld, nhold_vld;
  logic          sop_pend, nsop;
  logic          err_flag, nerr;
  logic [7:0]    nodat;
  logic          novld, nosop, noeop, noerr;

  always_ff @(posedge rxclk) begin
    if (rxrst) begin
      s1_byte <= 8'h00;
      s1_dv   <= 1'b0;
      s1_er   <= 1'b0;
    end else begin
      s1_byte <= {idat_l[3:0], idat_h[3:0]};
      s1_dv   <= idat_h[4];
      s1_er   <= idat_h[4] ^ idat_l[4];
    end
  end

  always_ff @(posedge rxclk) begin
    if (rxrst) begin
      state    <= IDLE;
      precnt   <= 4'd0;
      bcnt     <= '0;
      hold     <= 8'h00;
      hold_vld <= 1'b0;
      sop_pend <= 1'b0;
      err_flag <= 1'b0;
      odat     <= 8'h00;
      ovld     <= 1'b0;
      osop     <= 1'b0;
      oeop     <= 1'b0;
      oerr     <= 1'b0;
      oerrcnt  <= 16'h0000;
    end else begin
      state    <= nstate;
      precnt   <= nprecnt;
      bcnt     <= nbcnt;
      hold     <= nhold;
      hold_vld <= nhold_vld;
      sop_pend <= nsop;
      err_flag <= nerr;
      odat     <= nodat;
      ovld     <= novld;
      osop     <= nosop;
      oeop     <= noeop;
      oerr     <= noerr;
      if (noeop && noerr && (oerrcnt != 16'hFFFF))
        oerrcnt <= oerrcnt + 16'd1;
    end
  end

  // One byte of look-ahead in the hold register lets the last byte carry oeop.
  always_comb begin
    nstate    = state;
    nprecnt   = precnt;
    nbcnt     = bcnt;
    nhold     = hold;
    nhold_vld = hold_vld;
    nsop      = sop_pend;
    nerr      = err_flag;
    nodat     = odat;
    novld     = 1'b0;
    nosop     = 1'b0;
    noeop     = 1'b0;
    noerr     = 1'b0;
    case (state)
      IDLE: begin
        nbcnt     = '0;
        nhold_vld = 1'b0;
        nerr      = 1'b0;
        nsop      = 1'b1;
        if (s1_dv) begin
          if (s1_byte == 8'h55) begin
            nstate  = PRE;
            nprecnt = 4'd1;
          end else if ((s1_byte == 8'hD5) && (MINPRE == 0)) begin
            nstate = DATA;
          end else begin
            nstate = DROP;
          end
        end
      end
      PRE: begin
        if (!s1_dv) begin
          nstate = IDLE;
        end else if (s1_byte == 8'h55) begin
          if (precnt != 4'hF)
            nprecnt = precnt + 4'd1;
        end else if ((s1_byte == 8'hD5) && ({1'b0, precnt} >= MINPRE_C)) begin
          nstate = DATA;
        end else begin
          nstate = DROP;
        end
      end
      DATA: begin
        if (s1_dv) begin
          if (hold_vld && (bcnt == MAXLEN_C)) begin
            // Oversize: close the frame on the last allowed byte, discard the rest.
            novld     = 1'b1;
            nodat     = hold;
            nosop     = sop_pend;
            noeop     = 1'b1;
            noerr     = 1'b1;
            nhold_vld = 1'b0;
            nstate    = DROP;
          end else begin
            nhold     = s1_byte;
            nhold_vld = 1'b1;
            nbcnt     = bcnt + LW'(1);
            nerr      = err_flag | s1_er;
            if (hold_vld) begin
              novld = 1'b1;
              nodat = hold;
              nosop = sop_pend;
              nsop  = 1'b0;
            end
          end
        end else begin
          if (hold_vld) begin
            novld = 1'b1;
            nodat = hold;
            nosop = sop_pend;
            noeop = 1'b1;
            noerr = err_flag | s1_er;
          end
          nhold_vld = 1'b0;
          nstate    = IDLE;
        end
      end
      DROP: begin
        if (!s1_dv)
          nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

`ifdef IPSMACGE_INBAND_STS_EN
  logic [3:0] sts_prev;
  logic       sts_prev_vld;

  // Status is only accepted when two back-to-back idle cycles agree.
  always_ff @(posedge rxclk) begin
    if (rxrst) begin
      sts_prev     <= 4'h0;
      sts_prev_vld <= 1'b0;
      olink        <= 1'b0;
      ospeed       <= 2'b00;
      odplx        <= 1'b0;
    end else if ((state == IDLE) && !s1_dv && !s1_er) begin
      sts_prev     <= s1_byte[3:0];
      sts_prev_vld <= 1'b1;
      if (sts_prev_vld && (s1_byte[3:0] == sts_prev)) begin
        olink  <= s1_byte[0];
        ospeed <= s1_byte[2:1];
        odplx  <= s1_byte[3];
      end
    end else begin
      sts_prev_vld <= 1'b0;
    end
  end
`else
  assign olink  = 1'b0;
  assign ospeed = 2'b00;
  assign odplx  = 1'b0;
`endif

endmodule

// File: tb/tb_ipsmacge_rgmiirx.sv
// tb/tb_ipsmacge_rgmiirx.sv - self-checking bench: full-size and MAXLEN=16 instances against a frame-level model
module tb_ipsmacge_rgmiirx;

  localparam int TB_MINPRE = 1;

  logic        rxclk = 1'b0;
  logic        rxrst;
  logic [4:0]  idat_h, idat_l;

  logic [7:0]  o0_dat, o1_dat;
  logic        o0_vld, o0_sop, o0_eop, o0_err;
  logic        o1_vld, o1_sop, o1_eop, o1_err;
  logic [15:0] o0_errcnt, o1_errcnt;
  logic        o0_link, o1_link, o0_dplx, o1_dplx;
  logic [1:0]  o0_speed, o1_speed;

  typedef struct {
    logic [7:0] b;
    logic       sop;
    logic       eop;
    logic       err;
    int         due;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [7:0]  fbq[$];
  logic        feq[$];
  int          cyc = 0;
  int          ecnt0 = 0, ecnt1 = 0;
  int          n_cmp = 0, n_bad = 0;

  ipsmacge_rgmiirx #(.MINPRE(TB_MINPRE), .MAXLEN(1536), .LW(11)) dut0 (
    .rxclk(rxclk), .rxrst(rxrst), .idat_h(idat_h), .idat_l(idat_l),
    .odat(o0_dat), .ovld(o0_vld), .osop(o0_sop), .oeop(o0_eop), .oerr(o0_err),
    .oerrcnt(o0_errcnt), .olink(o0_link), .ospeed(o0_speed), .odplx(o0_dplx)
  );

  ipsmacge_rgmiirx #(.MINPRE(TB_MINPRE), .MAXLEN(16), .LW(5)) dut1 (
    .rxclk(rxclk), .rxrst(rxrst), .idat_h(idat_h), .idat_l(idat_l),
    .odat(o1_dat), .ovld(o1_vld), .osop(o1_sop), .oeop(o1_eop), .oerr(o1_err),
    .oerrcnt(o1_errcnt), .olink(o1_link), .ospeed(o1_speed), .odplx(o1_dplx)
  );

  always #5 rxclk = ~rxclk;
  always @(posedge rxclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] b, input logic rst);
    idat_h = {dv, b[3:0]};
    idat_l = {dv ^ er, b[7:4]};
    rxrst  = rst;
    @(posedge rxclk);
    #1;
  endtask

  // Frame-level rules: leading 0x55 run, then 0xD5, then data up to dv low.
  task automatic model(input int start, input int rst_idx, input int maxlen, input int which);
    int   i, ds, nd, nout;
    logic anyer;
    exp_t e;
    i = 0;
    while (i < fbq.size() && fbq[i] == 8'h55) i++;
    if (i >= fbq.size() || fbq[i] != 8'hD5 || ((i > 15) ? 15 : i) < TB_MINPRE) return;
    ds    = i + 1;
    nd    = fbq.size() - ds;
    nout  = (nd > maxlen) ? maxlen : nd;
    anyer = (nd > maxlen);
    for (int j = 0; j < nout; j++) anyer = anyer | feq[ds + j];
    for (int j = 0; j < nout; j++) begin
      if (rst_idx >= 0 && ds + j >= rst_idx - 2) break;
      e.b   = fbq[ds + j];
      e.sop = (j == 0);
      e.eop = (j == nout - 1);
      e.err = e.eop & anyer;
      e.due = start + ds + j + 3;
      if (which == 0) begin
        q0.push_back(e);
        if (e.err) ecnt0++;
      end else begin
        q1.push_back(e);
        if (e.err) ecnt1++;
      end
    end
  endtask

  task automatic send_frame(input int rst_idx, input int gap);
    int start;
    start = cyc;
    if (rst_idx >= 0) begin
      ecnt0 = 0;
      ecnt1 = 0;
    end
    model(start, rst_idx, 1536, 0);
    model(start, rst_idx, 16, 1);
    for (int k = 0; k < fbq.size(); k++) begin
      drive(1'b1, feq[k], fbq[k], k == rst_idx);
      if (k == rst_idx) begin
        chk("rst_ovld0", o0_vld, 0);
        chk("rst_odat0", o0_dat, 0);
        chk("rst_errcnt0", o0_errcnt, 0);
        chk("rst_ovld1", o1_vld, 0);
      end
    end
    drive(1'b0, 1'b0, 8'($urandom), 1'b0);
    for (int g = 1; g < gap; g++) drive(1'b0, 1'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic build(input int npre, input int ndata, input logic seq);
    fbq.delete();
    feq.delete();
    for (int k = 0; k < npre; k++) begin fbq.push_back(8'h55); feq.push_back(1'b0); end
    fbq.push_back(8'hD5); feq.push_back(1'b0);
    for (int k = 0; k < ndata; k++) begin
      fbq.push_back(seq ? 8'(k + 1) : 8'($urandom));
      feq.push_back(1'b0);
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 60) begin
      @(posedge rxclk);
      #1;
      t++;
    end
    chk({tag, "_drain0"}, q0.size(), 0);
    chk({tag, "_drain1"}, q1.size(), 0);
    chk({tag, "_errcnt0"}, o0_errcnt, ecnt0);
    chk({tag, "_errcnt1"}, o1_errcnt, ecnt1);
  endtask

  always @(negedge rxclk) begin
    logic ev;
    exp_t e;
    while (q0.size() > 0 && q0[0].due < cyc) begin
      chk("d0_late", cyc, q0[0].due);
      void'(q0.pop_front());
    end
    ev = (q0.size() > 0) && (q0[0].due == cyc);
    chk("d0_ovld", o0_vld, ev);
    if (ev && o0_vld) begin
      e = q0.pop_front();
      chk("d0_byte", {o0_sop, o0_eop, o0_err, o0_dat}, {e.sop, e.eop, e.err, e.b});
    end
  end

  always @(negedge rxclk) begin
    logic ev;
    exp_t e;
    while (q1.size() > 0 && q1[0].due < cyc) begin
      chk("d1_late", cyc, q1[0].due);
      void'(q1.pop_front());
    end
    ev = (q1.size() > 0) && (q1[0].due == cyc);
    chk("d1_ovld", o1_vld, ev);
    if (ev && o1_vld) begin
      e = q1.pop_front();
      chk("d1_byte", {o1_sop, o1_eop, o1_err, o1_dat}, {e.sop, e.eop, e.err, e.b});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idat_h = 5'h00;
    idat_l = 5'h00;
    rxrst  = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("reset_out0", {o0_vld, o0_sop, o0_eop, o0_err, o0_dat}, 0);
    chk("reset_cnt0", o0_errcnt, 0);
    chk("reset_sts0", {o0_link, o0_speed, o0_dplx}, 0);
    chk("reset_out1", {o1_vld, o1_sop, o1_eop, o1_err, o1_dat, o1_errcnt}, 0);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);

    build(7, 64, 1'b1);
    send_frame(-1, 1);
    drain("t1");

    build(7, 64, 1'b1);
    feq[8 + 31] = 1'b1;
    send_frame(-1, 1);
    drain("t2");
    chk("t2_errcnt_one", o0_errcnt, 1);

    fbq = '{8'h55, 8'h57, 8'h55, 8'h55, 8'hD5, 8'h11, 8'h22, 8'h33};
    feq = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(-1, 1);
    build(3, 12, 1'b0);
    send_frame(-1, 2);
    drain("t3");

    build(7, 20, 1'b1);
    send_frame(-1, 1);
    drain("t4");

    build(7, 64, 1'b1);
    send_frame(17, 1);
    build(7, 30, 1'b0);
    send_frame(-1, 1);
    drain("t5");

    build(1, 0, 1'b0);
    send_frame(-1, 1);
    build(1, 1, 1'b0);
    send_frame(-1, 1);
    build(2, 16, 1'b0);
    send_frame(-1, 1);
    drain("edge");

    for (int f = 0; f < 60; f++) begin
      build($urandom_range(0, 9), $urandom_range(0, 40), 1'b0);
      for (int k = 0; k < feq.size(); k++) feq[k] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) fbq[$urandom_range(0, 3)] = 8'($urandom);
      send_frame(-1, $urandom_range(1, 3));
    end
    drain("rand");

`ifdef IPSMACGE_INBAND_STS_EN
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("sts_zero", {o0_link, o0_speed, o0_dplx}, 4'b0000);
    repeat (4) drive(1'b0, 1'b0, 8'h0D, 1'b0);
    chk("sts_link", o0_link, 1);
    chk("sts_speed", o0_speed, 2'b10);
    chk("sts_dplx", o0_dplx, 1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h0D, 1'b0);
    chk("sts_glitch", {o0_link, o0_speed, o0_dplx}, 4'b1101);
    repeat (3) drive(1'b0, 1'b0, 8'h0D, 1'b0);
    chk("sts_hold", {o0_link, o0_speed, o0_dplx}, 4'b1101);
`else
    repeat (3) drive(1'b0, 1'b0, 8'h0D, 1'b0);
    chk("sts_tied0", {o0_link, o0_speed, o0_dplx}, 0);
    chk("sts_tied1", {o1_link, o1_speed, o1_dplx}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
